if_id_stage: RTL
================

IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: PC_if  input  32  address of the instruction currently fetched.
REQ-004 SHALL have port: Instruction_if  input  32  instruction word from fetch.
REQ-005 SHALL have port: IF_flush  input  1  fetch redirect (branch/jump taken) this cycle.
REQ-006 SHALL have port: MemRead_ex  input  1  the instruction in EX is a load.
REQ-007 SHALL have port: rt_ex  input  5  destination register of the load in EX.
REQ-008 SHALL have port: IFWrite  output  1  PC/fetch advance enable to the fetch stage.
REQ-009 SHALL have port: Stall_id  output  1  insert a bubble (zero controls) into ID/EX.
REQ-010 SHALL have port: NextPC_id  output  32  registered PC_if+4.
REQ-011 SHALL have port: Instruction_id  output  32  registered instruction.
REQ-012 SHALL have port: valid_id  output  1  Instruction_id is a real (non-flushed) instruction.
REQ-013 SHALL have port: rs_id, rt_id, rd_id  output  5 each  fields [25:21], [20:16], [15:11] of Instruction_id.
REQ-014 SHALL have port: imm_id  output  32  sign-extended Instruction_id[15:0].
REQ-015 SHALL have port: stall_count, flush_count  output  16 each  saturating event counters.

Function
REQ-016 Raw hazard SHALL be MemRead_ex && valid_id && rt_ex!=0 && (rt_ex==rs_id || rt_ex==rt_id), evaluated combinationally.
REQ-017 FSM SHALL have states RUN and STALL; RUN->STALL on effective hazard; STALL->RUN unconditionally after one cycle.
REQ-018 Effective hazard SHALL be raw hazard && state==RUN && !IF_flush; a stall therefore never exceeds one cycle.
REQ-019 IFWrite SHALL be !effective_hazard; Stall_id SHALL equal effective_hazard (both combinational, same cycle).
REQ-020 Register update priority at each clock edge SHALL be reset > IF_flush > effective_hazard (hold) > load.
REQ-021 On IF_flush: Instruction_id<=32'h0, NextPC_id<=PC_if+4, valid_id<=0; IFWrite stays 1 so the redirect target is taken.
REQ-022 On hold: NextPC_id, Instruction_id and valid_id SHALL keep their values.
REQ-023 On load: NextPC_id<=PC_if+4 (32-bit, wraps modulo 2^32), Instruction_id<=Instruction_if, valid_id<=1.
REQ-024 Field outputs and imm_id SHALL be combinational from Instruction_id; latency from fetch to ID is exactly one cycle.
REQ-025 stall_count SHALL increment on each cycle with effective_hazard; flush_count on each cycle with IF_flush; both saturate at 16'hFFFF.

Reset
REQ-026 On reset: state=RUN, Instruction_id=0, NextPC_id=0, valid_id=0, stall_count=0, flush_count=0; IFWrite=1 and Stall_id=0 during reset.
REQ-027 Reset asserted during STALL SHALL return to RUN the next edge with no pending hold.

Structure
REQ-028 Shared package SHALL hold NOP word (32'h0), FSM state encoding, and counter width (16).
REQ-029 Hazard comparison SHALL be one sub-module, hazard_detect; registers, FSM and counters stay in if_id_stage.

Verification
REQ-030 Reset, then PC_if=0x40, Instruction_if=0x8C220004 -> next cycle NextPC_id=0x44, Instruction_id=0x8C220004, valid_id=1.
REQ-031 ID holds add $3,$2,$4 (0x00441820), MemRead_ex=1, rt_ex=2 -> IFWrite=0, Stall_id=1 one cycle, ID held, then IFWrite=1, stall_count=1.
REQ-032 Same as REQ-031 with rt_ex=0 -> no stall, IFWrite=1.
REQ-033 IF_flush=1 together with hazard condition -> IFWrite=1, Stall_id=0, next cycle Instruction_id=0, valid_id=0, flush_count+1.
REQ-034 PC_if=0xFFFFFFFC load -> NextPC_id=0x00000000; flush_count preloaded to 0xFFFF plus IF_flush -> stays 0xFFFF.
REQ-035 Reset asserted in STALL -> next cycle state RUN, all outputs at REQ-026 values.

Source files
------------

// File: rtl/if_id_stage_pkg.sv
// Shared definitions for the IF/ID pipeline stage: NOP word, FSM encoding,
// event counter width and the saturating increment used by both counters.
package if_id_stage_pkg;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam int          CNT_W    = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/if_id_stage_hazard_detect.sv
// Load-use hazard compare: a load in EX writes a register that the
// instruction now in ID reads. Register $0 never creates a dependency.
module hazard_detect
    import if_id_stage_pkg::*;
(
    input  logic       MemRead_ex,
    input  logic       valid_id,
    input  logic [4:0] rt_ex,
    input  logic [4:0] rs_id,
    input  logic [4:0] rt_id,
    output logic       raw_hazard
);

    logic w_src_match;

    assign w_src_match = (rt_ex == rs_id) || (rt_ex == rt_id);
    assign raw_hazard  = MemRead_ex && valid_id && (rt_ex != 5'd0) && w_src_match;

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with one-cycle load-use stall FSM, flush handling
// and saturating stall/flush event counters.
module if_id_stage
    import if_id_stage_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      PC_if,
    input  logic [31:0]      Instruction_if,
    input  logic             IF_flush,
    input  logic             MemRead_ex,
    input  logic [4:0]       rt_ex,
    output logic             IFWrite,
    output logic             Stall_id,
    output logic [31:0]      NextPC_id,
    output logic [31:0]      Instruction_id,
    output logic             valid_id,
    output logic [4:0]       rs_id,
    output logic [4:0]       rt_id,
    output logic [4:0]       rd_id,
    output logic [31:0]      imm_id,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    state_e           r_state;
    state_e           w_next_state;
    logic [31:0]      r_instr;
    logic [31:0]      r_next_pc;
    logic             r_valid;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_raw_hazard;
    logic             w_eff_hazard;
    logic [31:0]      w_pc_plus4;

    assign w_pc_plus4 = PC_if + 32'd4;

    hazard_detect u_hazard_detect (
        .MemRead_ex (MemRead_ex),
        .valid_id   (r_valid),
        .rt_ex      (rt_ex),
        .rs_id      (r_instr[25:21]),
        .rt_id      (r_instr[20:16]),
        .raw_hazard (w_raw_hazard)
    );

    // Stall FSM next state; a hazard only takes effect from RUN, so a stall
    // can never last more than one cycle. Reset and flush both suppress it.
    always_comb begin
        w_next_state = r_state;
        w_eff_hazard = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_eff_hazard = w_raw_hazard && !IF_flush && !reset;
                if (w_eff_hazard) begin
                    w_next_state = ST_STALL;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_STALL: w_next_state = ST_RUN;
            default:  w_next_state = ST_RUN;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Pipeline register: flush beats hold, hold beats load
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr   <= NOP_WORD;
            r_next_pc <= 32'h0000_0000;
            r_valid   <= 1'b0;
        end else if (IF_flush) begin
            r_instr   <= NOP_WORD;
            r_next_pc <= w_pc_plus4;
            r_valid   <= 1'b0;
        end else if (w_eff_hazard) begin
            r_instr   <= r_instr;
            r_next_pc <= r_next_pc;
            r_valid   <= r_valid;
        end else begin
            r_instr   <= Instruction_if;
            r_next_pc <= w_pc_plus4;
            r_valid   <= 1'b1;
        end
    end

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= {CNT_W{1'b0}};
            r_flush_cnt <= {CNT_W{1'b0}};
        end else begin
            r_stall_cnt <= w_eff_hazard ? sat_inc(r_stall_cnt) : r_stall_cnt;
            r_flush_cnt <= IF_flush     ? sat_inc(r_flush_cnt) : r_flush_cnt;
        end
    end

    assign IFWrite        = !w_eff_hazard;
    assign Stall_id       = w_eff_hazard;
    assign NextPC_id      = r_next_pc;
    assign Instruction_id = r_instr;
    assign valid_id       = r_valid;
    assign rs_id          = r_instr[25:21];
    assign rt_id          = r_instr[20:16];
    assign rd_id          = r_instr[15:11];
    assign imm_id         = {{16{r_instr[15]}}, r_instr[15:0]};
    assign stall_count    = r_stall_cnt;
    assign flush_count    = r_flush_cnt;

endmodule
